// File: rtl/pifo_reg_sched.sv
// Register-based PIFO plus the sequencer that arbitrates enqueue/dequeue requesters onto it.
// One PIFO operation per four cycles so the min/max search settles before it is sampled again.

module pifo_reg #(
   parameter int L2_REG_WIDTH = 2,
   parameter int RANK_WIDTH   = 8,
   parameter int META_WIDTH   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    insert,
   input  logic                    remove,
   input  logic [RANK_WIDTH-1:0]   rank_in,
   input  logic [META_WIDTH-1:0]   meta_in,
   output logic [RANK_WIDTH-1:0]   rank_out,
   output logic [META_WIDTH-1:0]   meta_out,
   output logic [RANK_WIDTH-1:0]   max_rank_out,
   output logic [META_WIDTH-1:0]   max_meta_out,
   output logic [L2_REG_WIDTH:0]   num_entries
);
   localparam int CAP = 2 ** L2_REG_WIDTH;
   localparam logic [L2_REG_WIDTH:0] CAP_N = {1'b1, {L2_REG_WIDTH{1'b0}}};
   typedef logic [L2_REG_WIDTH-1:0] idx_t;

   logic [RANK_WIDTH-1:0] rank_q [CAP];
   logic [META_WIDTH-1:0] meta_q [CAP];
   logic [CAP-1:0]        used;
   logic [L2_REG_WIDTH:0] cnt;
   idx_t                  min_idx, max_idx, free_idx, wr_idx;
   logic [RANK_WIDTH-1:0] min_val, max_val;
   logic                  any_used, have_free, full;

   // Ties: minimum keeps the lowest slot, maximum the highest slot.
   always_comb begin
      min_idx   = '0;
      max_idx   = '0;
      free_idx  = '0;
      min_val   = '0;
      max_val   = '0;
      any_used  = 1'b0;
      have_free = 1'b0;
      for (int i = 0; i < CAP; i++) begin
         if (used[i]) begin
            if (!any_used || rank_q[i] < min_val) begin
               min_idx = idx_t'(i);
               min_val = rank_q[i];
            end
            if (!any_used || rank_q[i] >= max_val) begin
               max_idx = idx_t'(i);
               max_val = rank_q[i];
            end
            any_used = 1'b1;
         end else if (!have_free) begin
            free_idx  = idx_t'(i);
            have_free = 1'b1;
         end
      end
   end

   assign full         = (cnt == CAP_N);
   assign wr_idx       = full ? max_idx : free_idx;
   assign rank_out     = any_used ? rank_q[min_idx] : '0;
   assign meta_out     = any_used ? meta_q[min_idx] : '0;
   assign max_rank_out = any_used ? rank_q[max_idx] : '0;
   assign max_meta_out = any_used ? meta_q[max_idx] : '0;
   assign num_entries  = cnt;

   always_ff @(posedge clk) begin
      if (insert) begin
         rank_q[wr_idx] <= rank_in;
         meta_q[wr_idx] <= meta_in;
      end
   end

   // An insert into a full PIFO overwrites the max slot, so the count is unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         used <= '0;
         cnt  <= '0;
      end else if (insert) begin
         if (!full) begin
            used[free_idx] <= 1'b1;
            cnt            <= cnt + 1'b1;
         end
      end else if (remove && any_used) begin
         used[min_idx] <= 1'b0;
         cnt           <= cnt - 1'b1;
      end
   end
endmodule

module pifo_reg_sched #(
   parameter int NUM_PORTS     = 4,
   parameter int L2_REG_WIDTH  = 2,
   parameter int RANK_WIDTH    = 8,
   parameter int META_WIDTH    = 8,
   parameter int MAX_DEQ_BURST = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            enq_valid,
   input  logic [NUM_PORTS*RANK_WIDTH-1:0] enq_rank,
   input  logic [NUM_PORTS*META_WIDTH-1:0] enq_meta,
   output logic [NUM_PORTS-1:0]            enq_ready,
   input  logic                            deq_req,
   output logic                            deq_valid,
   output logic                            deq_empty,
   output logic [RANK_WIDTH-1:0]           deq_rank,
   output logic [META_WIDTH-1:0]           deq_meta,
   output logic                            drop_valid,
   output logic [RANK_WIDTH-1:0]           drop_rank,
   output logic [META_WIDTH-1:0]           drop_meta,
   output logic [31:0]                     drop_cnt,
   output logic [L2_REG_WIDTH:0]           occupancy
);
   localparam int PTR_W    = $clog2(NUM_PORTS);
   localparam int STREAK_W = $clog2(MAX_DEQ_BURST + 1);
   localparam logic [L2_REG_WIDTH:0] CAP_N   = {1'b1, {L2_REG_WIDTH{1'b0}}};
   localparam logic [STREAK_W-1:0]   BURST_N = STREAK_W'(MAX_DEQ_BURST);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT1, WAIT2} state_t;
   state_t state, state_nxt;

   logic [PTR_W-1:0]      rr_ptr, win, win_nxt;
   logic                  win_found, any_enq, deq_sel, enq_sel, full, empty;
   logic [STREAK_W-1:0]   deq_streak;
   logic                  ins_flag, rm_flag, pifo_insert, pifo_remove;
   logic [RANK_WIDTH-1:0] win_rank, rank_p0, pifo_rank, pifo_max_rank;
   logic [META_WIDTH-1:0] win_meta, meta_p0, pifo_meta, pifo_max_meta;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [STREAK_W-1:0] sat_streak(input logic [STREAK_W-1:0] v);
      return (v == BURST_N) ? v : v + 1'b1;
   endfunction

   always_comb begin
      win       = rr_ptr;
      win_found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         int j;
         j = (int'(rr_ptr) + k) % NUM_PORTS;
         if (!win_found && enq_valid[j]) begin
            win       = PTR_W'(j);
            win_found = 1'b1;
         end
      end
   end

   assign win_nxt  = (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
   assign win_rank = enq_rank[int'(win)*RANK_WIDTH +: RANK_WIDTH];
   assign win_meta = enq_meta[int'(win)*META_WIDTH +: META_WIDTH];
   assign any_enq  = |enq_valid;
   // A full dequeue burst yields to any waiting enqueue requester.
   assign deq_sel  = deq_req && !((deq_streak == BURST_N) && any_enq);
   assign enq_sel  = any_enq && !deq_sel;
   assign full     = (occupancy == CAP_N);
   assign empty    = (occupancy == '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      enq_ready = '0;
      case (state)
         IDLE: begin
            if (deq_sel || enq_sel) state_nxt = ISSUE;
            if (enq_sel) enq_ready[win] = 1'b1;
         end
         ISSUE:   state_nxt = WAIT1;
         WAIT1:   state_nxt = WAIT2;
         default: state_nxt = IDLE;
      endcase
   end

   // IDLE -> ISSUE boundary: grant decision and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         deq_valid  <= 1'b0;
         deq_empty  <= 1'b0;
         deq_rank   <= '0;
         deq_meta   <= '0;
         drop_valid <= 1'b0;
         drop_rank  <= '0;
         drop_meta  <= '0;
         drop_cnt   <= '0;
         rr_ptr     <= '0;
         deq_streak <= '0;
         ins_flag   <= 1'b0;
         rm_flag    <= 1'b0;
      end else begin
         deq_valid  <= 1'b0;
         deq_empty  <= 1'b0;
         drop_valid <= 1'b0;
         if (drop_valid) drop_cnt <= sat_inc32(drop_cnt);
         if (state == ISSUE) begin
            ins_flag <= 1'b0;
            rm_flag  <= 1'b0;
         end
         if (state == IDLE && deq_sel) begin
            deq_valid  <= 1'b1;
            deq_streak <= sat_streak(deq_streak);
            if (empty) begin
               deq_empty <= 1'b1;
               deq_rank  <= '0;
               deq_meta  <= '0;
            end else begin
               deq_rank <= pifo_rank;
               deq_meta <= pifo_meta;
               rm_flag  <= 1'b1;
            end
         end else if (state == IDLE && enq_sel) begin
            deq_streak <= '0;
            rr_ptr     <= win_nxt;
            if (full && win_rank >= pifo_max_rank) begin
               drop_valid <= 1'b1;
               drop_rank  <= win_rank;
               drop_meta  <= win_meta;
            end else begin
               ins_flag <= 1'b1;
               if (full) begin
                  drop_valid <= 1'b1;
                  drop_rank  <= pifo_max_rank;
                  drop_meta  <= pifo_max_meta;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && enq_sel) begin
         rank_p0 <= win_rank;
         meta_p0 <= win_meta;
      end
   end

   // ISSUE stage: one-cycle strobe into the PIFO; reset suppresses it.
   assign pifo_insert = (state == ISSUE) && ins_flag && !rst;
   assign pifo_remove = (state == ISSUE) && rm_flag && !rst;

   pifo_reg #(
      .L2_REG_WIDTH (L2_REG_WIDTH),
      .RANK_WIDTH   (RANK_WIDTH),
      .META_WIDTH   (META_WIDTH)
   ) u_pifo (
      .clk          (clk),
      .rst          (rst),
      .insert       (pifo_insert),
      .remove       (pifo_remove),
      .rank_in      (rank_p0),
      .meta_in      (meta_p0),
      .rank_out     (pifo_rank),
      .meta_out     (pifo_meta),
      .max_rank_out (pifo_max_rank),
      .max_meta_out (pifo_max_meta),
      .num_entries  (occupancy)
   );
endmodule

// File: tb/tb_pifo_reg_sched.sv
// Scoreboard bench for pifo_reg_sched: a 4-entry instance for the main scenarios and an
// 8-entry instance for the dequeue-burst starvation guard.

module tb_pifo_reg_sched;
   localparam int NP = 4;
   localparam int RW = 8;
   localparam int MW = 8;
   localparam int CAP = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NP-1:0]    enq_valid, enq_ready;
   logic [NP*RW-1:0] enq_rank;
   logic [NP*MW-1:0] enq_meta;
   logic             deq_req, deq_valid, deq_empty, drop_valid;
   logic [RW-1:0]    deq_rank, drop_rank;
   logic [MW-1:0]    deq_meta, drop_meta;
   logic [31:0]      drop_cnt;
   logic [2:0]       occupancy;

   logic [NP-1:0]    enq_valid_b, enq_ready_b;
   logic [NP*RW-1:0] enq_rank_b;
   logic [NP*MW-1:0] enq_meta_b;
   logic             deq_req_b, deq_valid_b, deq_empty_b, drop_valid_b;
   logic [RW-1:0]    deq_rank_b, drop_rank_b;
   logic [MW-1:0]    deq_meta_b, drop_meta_b;
   logic [31:0]      drop_cnt_b;
   logic [3:0]       occupancy_b;

   pifo_reg_sched #(.NUM_PORTS(NP), .L2_REG_WIDTH(2), .RANK_WIDTH(RW), .META_WIDTH(MW),
                    .MAX_DEQ_BURST(4)) dut (
      .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_rank(enq_rank), .enq_meta(enq_meta),
      .enq_ready(enq_ready), .deq_req(deq_req), .deq_valid(deq_valid), .deq_empty(deq_empty),
      .deq_rank(deq_rank), .deq_meta(deq_meta), .drop_valid(drop_valid), .drop_rank(drop_rank),
      .drop_meta(drop_meta), .drop_cnt(drop_cnt), .occupancy(occupancy));

   pifo_reg_sched #(.NUM_PORTS(NP), .L2_REG_WIDTH(3), .RANK_WIDTH(RW), .META_WIDTH(MW),
                    .MAX_DEQ_BURST(4)) dut_b (
      .clk(clk), .rst(rst), .enq_valid(enq_valid_b), .enq_rank(enq_rank_b),
      .enq_meta(enq_meta_b), .enq_ready(enq_ready_b), .deq_req(deq_req_b),
      .deq_valid(deq_valid_b), .deq_empty(deq_empty_b), .deq_rank(deq_rank_b),
      .deq_meta(deq_meta_b), .drop_valid(drop_valid_b), .drop_rank(drop_rank_b),
      .drop_meta(drop_meta_b), .drop_cnt(drop_cnt_b), .occupancy(occupancy_b));

   typedef struct packed {
      logic [7:0] rank;
      logic [7:0] meta;
      logic       empty;
   } item_t;

   item_t model[$];
   item_t deq_q[$];
   item_t drop_q[$];
   item_t mon_e;
   int    total = 0;
   int    bad = 0;
   int    cycle = 0;

   always @(posedge clk) cycle++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_insert(input logic [7:0] r, input logic [7:0] m);
      item_t it;
      int    mx;
      it.rank  = r;
      it.meta  = m;
      it.empty = 1'b0;
      if (model.size() < CAP) begin
         model.push_back(it);
         return;
      end
      mx = 0;
      for (int i = 1; i < model.size(); i++)
         if (model[i].rank > model[mx].rank) mx = i;
      if (r >= model[mx].rank) begin
         drop_q.push_back(it);
      end else begin
         drop_q.push_back(model[mx]);
         model[mx] = it;
      end
   endfunction

   function automatic void model_remove();
      item_t it;
      int    mn;
      if (model.size() == 0) begin
         it.rank  = 8'd0;
         it.meta  = 8'd0;
         it.empty = 1'b1;
         deq_q.push_back(it);
         return;
      end
      mn = 0;
      for (int i = 1; i < model.size(); i++)
         if (model[i].rank < model[mn].rank) mn = i;
      deq_q.push_back(model[mn]);
      model.delete(mn);
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (deq_valid) begin
            if (deq_q.size() == 0) begin
               check("deq_unexpected", 1, 0);
            end else begin
               mon_e = deq_q.pop_front();
               check("deq_rank", deq_rank, mon_e.rank);
               check("deq_meta", deq_meta, mon_e.meta);
               check("deq_empty", deq_empty, mon_e.empty);
            end
         end
         if (drop_valid) begin
            if (drop_q.size() == 0) begin
               check("drop_unexpected", 1, 0);
            end else begin
               mon_e = drop_q.pop_front();
               check("drop_rank", drop_rank, mon_e.rank);
               check("drop_meta", drop_meta, mon_e.meta);
            end
         end
         if (|enq_ready) check("ready_onehot", $onehot(enq_ready), 1);
      end
   end

   task automatic enq(input int p, input logic [7:0] r, input logic [7:0] m);
      int n = 0;
      enq_valid[p] = 1'b1;
      enq_rank[p*RW +: RW] = r;
      enq_meta[p*MW +: MW] = m;
      @(negedge clk);
      while (!enq_ready[p] && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!enq_ready[p]) check("enq_timeout", 0, 1);
      else model_insert(r, m);
      @(posedge clk);
      #1 enq_valid[p] = 1'b0;
   endtask

   task automatic deq(output int lat);
      int n = 0;
      model_remove();
      deq_req = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!deq_valid && n < 40);
      lat = n - 1;
      if (!deq_valid) check("deq_timeout", 0, 1);
      @(posedge clk);
      #1 deq_req = 1'b0;
   endtask

   task automatic enq_b(input int p, input logic [7:0] r, input logic [7:0] m);
      int n = 0;
      enq_valid_b[p] = 1'b1;
      enq_rank_b[p*RW +: RW] = r;
      enq_meta_b[p*MW +: MW] = m;
      @(negedge clk);
      while (!enq_ready_b[p] && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!enq_ready_b[p]) check("enq_b_timeout", 0, 1);
      @(posedge clk);
      #1 enq_valid_b[p] = 1'b0;
   endtask

   task automatic settle();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model.delete();
      deq_q.delete();
      drop_q.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p, last, n, nd;
      int exp_evt[7] = '{1, 1, 1, 1, 0, 1, 1};
      logic [7:0] exp_rk[6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      logic [7:0] rr_rank[4] = '{8'd40, 8'd30, 8'd20, 8'd10};

      rst = 1'b1;
      enq_valid = '0; enq_rank = '0; enq_meta = '0; deq_req = 1'b0;
      enq_valid_b = '0; enq_rank_b = '0; enq_meta_b = '0; deq_req_b = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_occ", occupancy, 0);
      check("rst_ready", enq_ready, 0);
      check("rst_deq_valid", deq_valid, 0);
      check("rst_drop_valid", drop_valid, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      @(posedge clk);
      #1;

      // empty dequeue
      deq(lat);
      check("empty_deq_latency", lat, 1);
      settle();
      check("empty_deq_occ", occupancy, 0);

      // overflow, new entry dropped; then a freed slot takes an insert without a drop
      do_reset();
      for (int i = 5; i <= 8; i++) enq(2, 8'(i), 8'(i));
      enq(2, 8'd9, 8'hAA);
      settle();
      check("ovf_drop_cnt", drop_cnt, 1);
      check("ovf_occ", occupancy, 4);
      deq(lat);
      enq(2, 8'd9, 8'h99);
      settle();
      check("refill_drop_cnt", drop_cnt, 1);
      check("refill_occ", occupancy, 4);
      for (int i = 0; i < 4; i++) deq(lat);
      settle();
      check("drain_occ", occupancy, 0);

      // overflow, max entry evicted
      do_reset();
      for (int i = 5; i <= 8; i++) enq(2, 8'(i), 8'(i));
      enq(2, 8'd1, 8'h01);
      settle();
      check("evict_drop_cnt", drop_cnt, 1);
      check("evict_occ", occupancy, 4);
      for (int i = 0; i < 4; i++) deq(lat);
      settle();

      // reset during the ISSUE cycle of an insert
      enq_valid[1] = 1'b1;
      enq_rank[1*RW +: RW] = 8'd33;
      enq_meta[1*MW +: MW] = 8'h33;
      n = 0;
      @(negedge clk);
      while (!enq_ready[1] && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("midrst_grant", enq_ready[1], 1);
      @(posedge clk);
      #1 enq_valid[1] = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_occ", occupancy, 0);
      check("midrst_deq_rank", deq_rank, 0);
      check("midrst_deq_meta", deq_meta, 0);
      check("midrst_drop_rank", drop_rank, 0);
      check("midrst_drop_meta", drop_meta, 0);
      check("midrst_drop_cnt", drop_cnt, 0);
      check("midrst_flags", {deq_valid, deq_empty, drop_valid, enq_ready}, 0);
      settle();
      check("midrst_occ_later", occupancy, 0);
      model.delete();
      deq_q.delete();
      drop_q.delete();

      // round-robin from port 0 after reset
      for (int i = 0; i < NP; i++) begin
         enq_rank[i*RW +: RW] = rr_rank[i];
         enq_meta[i*MW +: MW] = 8'hA0 + 8'(i);
      end
      enq_valid = 4'b1111;
      last = 0;
      for (int g = 0; g < NP; g++) begin
         n = 0;
         @(negedge clk);
         while (enq_ready == '0 && n < 40) begin
            n++;
            @(negedge clk);
         end
         if (enq_ready == '0) begin
            check("rr_timeout", 0, 1);
            break;
         end
         p = 0;
         for (int b = 0; b < NP; b++) if (enq_ready[b]) p = b;
         check("rr_port", p, g);
         if (g > 0) check("rr_spacing", cycle - last, 4);
         last = cycle;
         model_insert(enq_rank[p*RW +: RW], enq_meta[p*MW +: MW]);
         @(posedge clk);
         #1 enq_valid[p] = 1'b0;
      end
      enq_valid = '0;
      settle();
      check("rr_occ", occupancy, 4);
      for (int i = 0; i < 4; i++) deq(lat);
      settle();
      check("rr_occ_end", occupancy, 0);
      check("rr_sb_empty", deq_q.size() + drop_q.size(), 0);

      // starvation guard on the 8-entry instance
      for (int i = 1; i <= 8; i++) enq_b(0, 8'(i), 8'(i));
      settle();
      check("starve_preload_occ", occupancy_b, 8);
      deq_req_b = 1'b1;
      enq_valid_b[2] = 1'b1;
      enq_rank_b[2*RW +: RW] = 8'd100;
      enq_meta_b[2*MW +: MW] = 8'h64;
      n = 0;
      nd = 0;
      for (int k = 0; k < 200 && n < 7; k++) begin
         @(negedge clk);
         if (deq_valid_b) begin
            check("starve_evt", 1, exp_evt[n]);
            if (nd < 6) check("starve_rank", deq_rank_b, exp_rk[nd]);
            nd++;
            n++;
         end else if (enq_ready_b[2]) begin
            check("starve_evt", 0, exp_evt[n]);
            n++;
            @(posedge clk);
            #1 enq_valid_b[2] = 1'b0;
         end
      end
      check("starve_events", n, 7);
      @(posedge clk);
      #1 deq_req_b = 1'b0;
      enq_valid_b = '0;
      settle();
      check("starve_occ", occupancy_b, 3);
      check("starve_drop_cnt", drop_cnt_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
